// File: rtl/program_loader_pkg.sv
// Shared CPU package: instruction/PC widths and the program loader state encoding.
`default_nettype none

package program_loader_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int PC_WIDTH    = 16;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_BYTE0 = 3'd1,
    LD_BYTE1 = 3'd2,
    LD_BYTE2 = 3'd3,
    LD_WRITE = 3'd4,
    LD_DONE  = 3'd5,
    LD_ERROR = 3'd6
  } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/program_loader.sv
// Serial byte loader: assembles 20-bit instructions from 3 bytes, writes them
// to instruction memory and holds the CPU in reset until the load completes.
`default_nettype none

module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    word_count,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [PC_WIDTH-1:0]    mem_address,
  output logic [INSTR_WIDTH-1:0] mem_data,
  output logic                   mem_wren,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error
);

  localparam logic [31:0] C_DEPTH = 32'(DEPTH);

  loader_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]    count_q, count_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [15:0]            low_q, low_d;
  logic [PC_WIDTH-1:0]    mem_address_q, mem_address_d;
  logic [INSTR_WIDTH-1:0] mem_data_q, mem_data_d;

  logic w_xfer;
  logic w_start_ok;

  assign byte_ready = (state_q == LD_BYTE0) || (state_q == LD_BYTE1) || (state_q == LD_BYTE2);
  assign w_xfer     = byte_valid && byte_ready;
  assign w_start_ok = (word_count != '0) && (32'(word_count) <= C_DEPTH);

  assign mem_wren    = (state_q == LD_WRITE);
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign done        = (state_q == LD_DONE);
  assign error       = (state_q == LD_ERROR);
  assign cpu_reset   = (state_q != LD_DONE);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    addr_d        = addr_q;
    low_d         = low_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;

    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) begin
          if (w_start_ok) begin
            state_d = LD_BYTE0;
            count_d = word_count;
            addr_d  = '0;
          end else begin
            state_d = LD_ERROR;
          end
        end
      end
      LD_BYTE0: begin
        if (w_xfer) begin
          low_d[7:0] = byte_in;
          state_d    = LD_BYTE1;
        end
      end
      LD_BYTE1: begin
        if (w_xfer) begin
          low_d[15:8] = byte_in;
          state_d     = LD_BYTE2;
        end
      end
      LD_BYTE2: begin
        if (w_xfer) begin
          if (byte_in[7:4] != 4'h0) begin
            state_d = LD_ERROR;
          end else begin
            // Stage the write so mem_address/mem_data hold after the strobe.
            mem_address_d = addr_q;
            mem_data_d    = {byte_in[3:0], low_q};
            state_d       = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        if (addr_q == count_q - 16'd1) begin
          state_d = LD_DONE;
        end else begin
          addr_d  = addr_q + 16'd1;
          state_d = LD_BYTE0;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LD_IDLE;
      count_q       <= '0;
      addr_q        <= '0;
      low_q         <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      low_q         <= low_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// Bench for program_loader: start-validity table, directed load sequences and
// randomized loads checked against a word-list reference model.
`default_nettype none

module tb_program_loader;
  import program_loader_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] mem_address;
  logic [19:0] mem_data;
  logic        mem_wren;
  logic        cpu_reset;
  logic        done;
  logic        error;

  program_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int wr_pulses   = 0;

  always @(negedge clk) if (mem_wren) wr_pulses++;

  logic [19:0] ld_words [8];

  typedef struct {
    logic [15:0] wc;
    bit          exp_err;
  } start_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals;
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
  endtask

  // Offer one byte after 'gap' idle cycles; optionally pulse start alongside it.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit glitch);
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("ready_wait", byte_ready, 1);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    for (int k = 0; k < 20 && !byte_ready; k++) tick();
    if (!byte_ready) chk("ready_timeout", byte_ready, 1);
    if (glitch) begin
      start      = 1'b1;
      word_count = 16'd1;
    end
    tick();
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  // Reference behaviour: word i lands at address i one cycle after its third
  // byte; a bad high nibble on word bad_idx aborts with only earlier words written.
  task automatic do_load(input int wc, input int gap, input int bad_idx,
                         input logic [3:0] bad_nib, input bit glitch);
    int          base;
    logic [19:0] w;
    logic [7:0]  hi;
    base       = wr_pulses;
    start      = 1'b1;
    word_count = 16'(wc);
    tick();
    start = 1'b0;
    chk("start_ready", byte_ready, 1);
    chk("start_error", error, 0);
    chk("start_cpu_reset", cpu_reset, 1);
    for (int i = 0; i < wc; i++) begin
      w = ld_words[i];
      send_byte(w[7:0], gap, 1'b0);
      send_byte(w[15:8], gap, glitch && (i == 0));
      hi = (i == bad_idx) ? {bad_nib, w[19:16]} : {4'h0, w[19:16]};
      send_byte(hi, gap, 1'b0);
      if (i == bad_idx) begin
        chk("bad_error", error, 1);
        chk("bad_wren", mem_wren, 0);
        chk("bad_ready", byte_ready, 0);
        chk("bad_cpu_reset", cpu_reset, 1);
        chk("bad_writes", wr_pulses - base, i);
        return;
      end
      chk("wr_wren", mem_wren, 1);
      chk("wr_addr", mem_address, i);
      chk("wr_data", mem_data, w);
    end
    tick();
    chk("done", done, 1);
    chk("done_cpu_reset", cpu_reset, 0);
    chk("done_ready", byte_ready, 0);
    chk("done_wren", mem_wren, 0);
    chk("hold_addr", mem_address, wc - 1);
    chk("hold_data", mem_data, ld_words[wc-1]);
    chk("total_writes", wr_pulses - base, wc);
  endtask

  start_vec_t svec [8];

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_reset_vals();

    // Start-validity table, applied from IDLE or ERROR.
    svec[0] = '{16'd0,     1'b1};
    svec[1] = '{16'd1,     1'b0};
    svec[2] = '{16'd2,     1'b0};
    svec[3] = '{16'd255,   1'b0};
    svec[4] = '{16'd256,   1'b0};
    svec[5] = '{16'd257,   1'b1};
    svec[6] = '{16'd300,   1'b1};
    svec[7] = '{16'hFFFF,  1'b1};
    for (int v = 0; v < 8; v++) begin
      base       = wr_pulses;
      start      = 1'b1;
      word_count = svec[v].wc;
      tick();
      start = 1'b0;
      chk("tbl_error", error, svec[v].exp_err);
      chk("tbl_ready", byte_ready, !svec[v].exp_err);
      chk("tbl_cpu_reset", cpu_reset, 1);
      tick();
      chk("tbl_no_write", wr_pulses - base, 0);
      if (!svec[v].exp_err) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
    end

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; word_count = 16'd2;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_prio_ready", byte_ready, 0);
    chk_reset_vals();

    // Two-word load, back to back, then with 3-cycle gaps.
    ld_words[0] = 20'h51234;
    ld_words[1] = 20'hFABCD;
    do_load(2, 0, -1, 4'h0, 1'b0);
    do_load(2, 3, -1, 4'h0, 1'b0);

    // Invalid counts, then recovery with a one-word load.
    start = 1'b1; word_count = 16'd0; tick(); start = 1'b0;
    chk("zero_error", error, 1);
    start = 1'b1; word_count = 16'(DEPTH + 1); tick(); start = 1'b0;
    chk("over_error", error, 1);
    chk("over_cpu_reset", cpu_reset, 1);
    ld_words[0] = 20'h00001;
    do_load(1, 0, -1, 4'h0, 1'b0);

    // Third byte 0x10 aborts the load.
    ld_words[0] = 20'h00000;
    do_load(1, 0, 0, 4'h1, 1'b0);

    // Reset after the second byte of word 3, then reload from address 0.
    for (int i = 0; i < 4; i++) ld_words[i] = 20'(32'h1000 * i + 32'h11);
    base = wr_pulses;
    start = 1'b1; word_count = 16'd4; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_byte(ld_words[i][7:0], 0, 1'b0);
      send_byte(ld_words[i][15:8], 0, 1'b0);
      send_byte({4'h0, ld_words[i][19:16]}, 0, 1'b0);
    end
    send_byte(ld_words[2][7:0], 0, 1'b0);
    send_byte(ld_words[2][15:8], 0, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_reset_vals();
    chk("midload_writes", wr_pulses - base, 2);
    ld_words[0] = 20'h2468A;
    do_load(1, 1, -1, 4'h0, 1'b0);

    // Start pulsed during BYTE1 must not shorten the load.
    ld_words[0] = 20'h13579;
    ld_words[1] = 20'h0BEEF;
    ld_words[2] = 20'hC0DE5;
    do_load(3, 0, -1, 4'h0, 1'b1);

    // Randomized loads against the word-list model.
    for (int r = 0; r < 25; r++) begin
      int wc;
      int bad;
      wc = 1 + int'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) ld_words[i] = 20'($urandom);
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, wc - 1)) : -1;
      do_load(wc, int'($urandom_range(0, 2)), bad, 4'($urandom_range(1, 15)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 256, is the instruction ROM capacity in 20-bit words.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERROR.
REQ-005 word_count  input  16  number of instructions to load; sampled with start.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle; transfer occurs on byte_valid && byte_ready.
REQ-009 mem_address  output  16  instruction-memory write address.
REQ-010 mem_data  output  20  assembled instruction.
REQ-011 mem_wren  output  1  one-cycle instruction-memory write strobe.
REQ-012 cpu_reset  output  1  holds the CPU pipeline in reset while high.
REQ-013 done  output  1  load completed; CPU released.
REQ-014 error  output  1  load aborted; CPU held in reset.

Function
REQ-015 States SHALL be IDLE, BYTE0, BYTE1, BYTE2, WRITE, DONE and ERROR.
REQ-016 IDLE: byte_ready=0, cpu_reset=1; start with word_count==0 or word_count>DEPTH -> ERROR; other start -> BYTE0, latch count, clear address counter to 0.
REQ-017 BYTE0/BYTE1/BYTE2: byte_ready=1; a transfer stores byte_in as instruction bits [7:0]/[15:8]/[19:16] respectively and advances state; no transfer -> state unchanged.
REQ-018 BYTE2: transfer with byte_in[7:4]!=0 -> ERROR, no memory write.
REQ-019 WRITE: byte_ready=0; mem_wren=1 for exactly this cycle, with mem_address = current counter and mem_data = assembled word.
REQ-020 mem_wren SHALL assert the cycle immediately after the BYTE2 transfer (1-cycle latency); peak throughput is 3 bytes per 4 cycles.
REQ-021 WRITE exit: counter == count-1 -> DONE; otherwise increment counter -> BYTE0.
REQ-022 mem_wren=0 in every state except WRITE; mem_address and mem_data SHALL hold their last value outside WRITE.
REQ-023 DONE: done=1, cpu_reset=0, byte_ready=0; valid start re-enters BYTE0 (cpu_reset=1 again the next cycle); invalid start -> ERROR.
REQ-024 ERROR: error=1, cpu_reset=1, byte_ready=0; start behaves as in IDLE and clears error when leaving ERROR.
REQ-025 start SHALL be ignored in BYTE0, BYTE1, BYTE2 and WRITE.
REQ-026 Counter SHALL be 16 bits; because count<=DEPTH<=65536, it never wraps during a load.
REQ-027 byte_valid while byte_ready=0 SHALL be ignored; bytes are not buffered.

Reset
REQ-028 reset, at any cycle including mid-load, SHALL on the next edge force IDLE, counter=0, mem_address=0, mem_data=0, mem_wren=0, byte_ready=0, done=0, error=0, cpu_reset=1.
REQ-029 reset SHALL take priority over start and byte transfers in the same cycle.

Structure
REQ-030 INSTR_WIDTH=20, PC_WIDTH=16 and the loader state enum SHALL live in the shared CPU package.
REQ-031 Implementation SHALL be a single module; byte assembly stays inline and no sub-module is required.

Verification
REQ-032 Load 2 words, bytes 0x34,0x12,0x05,0xCD,0xAB,0x0F with byte_valid held high -> writes (addr 0, 0x51234) and (addr 1, 0xFABCD), each pulse 1 cycle after the third byte; done=1 and cpu_reset=0 after the second write.
REQ-033 Same load with byte_valid low for 3 cycles between each byte -> identical writes, no extra mem_wren, byte_ready held high while waiting.
REQ-034 start with word_count=0, then word_count=DEPTH+1 -> error=1, no mem_wren, cpu_reset=1; then start with word_count=1 and bytes 0x01,0x00,0x00 -> error=0, write (0, 0x00001), done=1.
REQ-035 Third byte 0x10 -> ERROR, no write, byte_ready=0.
REQ-036 reset asserted after the BYTE1 transfer of word 3 -> next cycle all outputs at reset values; new start reloads from address 0.
REQ-037 start pulsed during BYTE1 -> ignored; load completes with original count.
